disp_scan_ctrl: RTL and testbench



---
 rtl/disp_scan_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexes one BCD-to-7-segment decoder across a
// 4-digit common-anode display.
//
// Each digit gets a slot of REFRESH_DIV cycles. During the first BLANK_CYCLES
// cycles of a slot all anodes are off, so the previous digit's code cannot
// ghost onto the next anode. New display data arrives through a load strobe.
// It is held as pending and copied to the active registers only at a frame
// boundary, so a frame never mixes old and new data.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   load     one-cycle strobe; captures value_in, mode_in and lzb_in
//   value_in four BCD digits, [15:12] = digit 3 (leftmost), [3:0] = digit 0
//   mode_in  0 numeric, 1 "GO", 2 "BUS", 3 blank
//   lzb_in   leading-zero blanking enable (numeric mode only)
//   BCDout   code to the decoder: 0-9, 10 G, 11 B, 12 U, 13 F, 14 S, 15 space
//   an       active-low anode enables; an[i] drives digit i
//   busy     a captured load is waiting for a frame boundary
//   err      the committed numeric value contains a nibble > 9
//
// Load handshake states:
//   state    | meaning
//   ST_IDLE  | nothing pending; active registers are current
//   ST_PEND  | pending registers hold a load waiting for the frame boundary
module disp_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [1:0]  mode_in,
    input  logic        lzb_in,
    output logic [3:0]  BCDout,
    output logic [3:0]  an,
    output logic        busy,
    output logic        err
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    localparam logic [1:0] MODE_NUM   = 2'd0;
    localparam logic [1:0] MODE_GO    = 2'd1;
    localparam logic [1:0] MODE_BUS   = 2'd2;
    localparam logic [3:0] CODE_SPACE = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } ld_state_e;

    ld_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          err_q, err_d;

    logic [15:0]   pend_val_q, pend_val_d;
    logic [1:0]    pend_mode_q, pend_mode_d;
    logic          pend_lzb_q, pend_lzb_d;

    logic [15:0]   act_val_q, act_val_d;
    logic [1:0]    act_mode_q, act_mode_d;
    logic          act_lzb_q, act_lzb_d;

    logic          tick;
    logic          frame_end;

    // Code shown on digit idx for a given set of display registers.
    function automatic logic [3:0] digit_code(
        input logic [1:0]  mode,
        input logic [15:0] val,
        input logic        lzb,
        input logic [1:0]  idx
    );
        logic [3:0]  nib;
        logic [15:0] upper;
        logic [3:0]  code;
        nib   = val[{idx, 2'b00} +: 4];
        // This digit together with every more significant digit.
        upper = val >> {idx, 2'b00};
        code  = CODE_SPACE;
        case (mode)
            MODE_NUM: begin
                code = (nib > 4'd9) ? CODE_SPACE : nib;
                if (lzb && (idx != 2'd0) && (upper == 16'd0)) begin
                    code = CODE_SPACE;
                end
            end
            MODE_GO: begin
                case (idx)
                    2'd1:    code = 4'd10;
                    2'd0:    code = 4'd0;
                    default: code = CODE_SPACE;
                endcase
            end
            MODE_BUS: begin
                case (idx)
                    2'd2:    code = 4'd11;
                    2'd1:    code = 4'd12;
                    2'd0:    code = 4'd14;
                    default: code = CODE_SPACE;
                endcase
            end
            default: code = CODE_SPACE;
        endcase
        return code;
    endfunction

    function automatic logic value_bad(input logic [1:0] mode, input logic [15:0] val);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (val[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return (mode == MODE_NUM) && bad;
    endfunction

    always_comb begin
        state_d     = state_q;
        pend_val_d  = pend_val_q;
        pend_mode_d = pend_mode_q;
        pend_lzb_d  = pend_lzb_q;
        act_val_d   = act_val_q;
        act_mode_d  = act_mode_q;
        act_lzb_d   = act_lzb_q;
        err_d       = err_q;

        tick      = (cnt_q == CNT_MAX);
        frame_end = tick && (idx_q == 2'd3);

        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;

        if (frame_end) begin
            // A load on the boundary itself wins over anything pending.
            if (load) begin
                act_val_d  = value_in;
                act_mode_d = mode_in;
                act_lzb_d  = lzb_in;
                err_d      = value_bad(mode_in, value_in);
            end else if (state_q == ST_PEND) begin
                act_val_d  = pend_val_q;
                act_mode_d = pend_mode_q;
                act_lzb_d  = pend_lzb_q;
                err_d      = value_bad(pend_mode_q, pend_val_q);
            end
            state_d = ST_IDLE;
        end else if (load) begin
            pend_val_d  = value_in;
            pend_mode_d = mode_in;
            pend_lzb_d  = lzb_in;
            state_d     = ST_PEND;
        end

        // Outputs are computed from the next-cycle index and active data so
        // the code and the anode switch on the same edge as the index.
        an_d  = (cnt_d < CNT_BLANK) ? 4'b1111 : ~(4'b0001 << idx_d);
        bcd_d = digit_code(act_mode_d, act_val_d, act_lzb_d, idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            an_q        <= 4'b1111;
            bcd_q       <= CODE_SPACE;
            err_q       <= 1'b0;
            pend_val_q  <= 16'd0;
            pend_mode_q <= 2'd3;
            pend_lzb_q  <= 1'b0;
            act_val_q   <= 16'd0;
            act_mode_q  <= 2'd3;
            act_lzb_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            bcd_q       <= bcd_d;
            err_q       <= err_d;
            pend_val_q  <= pend_val_d;
            pend_mode_q <= pend_mode_d;
            pend_lzb_q  <= pend_lzb_d;
            act_val_q   <= act_val_d;
            act_mode_q  <= act_mode_d;
            act_lzb_q   <= act_lzb_d;
        end
    end

    assign BCDout = bcd_q;
    assign an     = an_q;
    assign busy   = (state_q == ST_PEND);
    assign err    = err_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
// Expected frames are pushed to a queue when a load is driven and popped
// when the following frame is scanned out.
module tb_disp_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'd0;
    logic [1:0]  mode_in = 2'd0;
    logic        lzb_in = 1'b0;
    logic [3:0]  BCDout;
    logic [3:0]  an;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value_in (value_in),
        .mode_in  (mode_in),
        .lzb_in   (lzb_in),
        .BCDout   (BCDout),
        .an       (an),
        .busy     (busy),
        .err      (err)
    );

    typedef struct packed {
        logic [15:0] codes;   // {digit3, digit2, digit1, digit0}
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [15:0] value;
        logic [1:0]  mode;
        logic        lzb;
        logic [15:0] codes;
        logic        err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    int checks = 0;
    int errors = 0;

    // Reference slot timing.
    int ref_cnt;
    int ref_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= 0;
            ref_idx <= 0;
        end else if (ref_cnt == RD - 1) begin
            ref_cnt <= 0;
            ref_idx <= (ref_idx + 1) % 4;
        end else begin
            ref_cnt <= ref_cnt + 1;
        end
    end

    // Anode pattern every cycle; code stable within a slot.
    logic [3:0] prev_bcd = 4'd15;
    always @(negedge clk) begin
        logic [3:0] ea;
        ea = (ref_cnt < BC) ? 4'b1111 : ~(4'b0001 << ref_idx);
        checks++;
        if (an !== ea) begin
            errors++;
            $display("FAIL an_scan t=%0t: got %b expected %b", $time, an, ea);
        end
        if (rst_n && ref_cnt != 0) begin
            checks++;
            if (BCDout !== prev_bcd) begin
                errors++;
                $display("FAIL bcd_stable t=%0t: got %0d expected %0d", $time, BCDout, prev_bcd);
            end
        end
        prev_bcd <= BCDout;
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic expect_frame(input logic [15:0] codes, input logic e);
        exp_t x;
        x.codes = codes;
        x.err   = e;
        sb.push_back(x);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [1:0] m, input logic l);
        value_in = v;
        mode_in  = m;
        lzb_in   = l;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic to_frame_start();
        int n = 0;
        while (!(ref_idx == 0 && ref_cnt == 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL frame_start_timeout: got no frame start expected one within 100 cycles");
        end
    endtask

    task automatic to_boundary();
        int n = 0;
        while (!(ref_idx == 3 && ref_cnt == RD - 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL boundary_timeout: got no boundary expected one within 100 cycles");
        end
    endtask

    task automatic check_frame(input string name);
        exp_t        e;
        logic [15:0] got;
        to_frame_start();
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got empty scoreboard expected a queued frame", name);
            return;
        end
        e = sb.pop_front();
        chk({name, "_busy"}, {15'd0, busy}, 16'd0);
        chk({name, "_err"}, {15'd0, err}, {15'd0, e.err});
        got = 16'd0;
        for (int i = 0; i < 4; i++) begin
            repeat (BC) @(negedge clk);
            got[i*4 +: 4] = BCDout;
            repeat (RD - BC) @(negedge clk);
        end
        chk({name, "_codes"}, got, e.codes);
    endtask

    initial begin
        vecs[0] = '{16'h0A05, 2'd0, 1'b1, 16'hFF05, 1'b1};
        vecs[1] = '{16'h1234, 2'd3, 1'b0, 16'hFFFF, 1'b0};
        vecs[2] = '{16'h12A4, 2'd0, 1'b0, 16'h12F4, 1'b1};
        vecs[3] = '{16'h1234, 2'd0, 1'b0, 16'h1234, 1'b0};
        vecs[4] = '{16'h0047, 2'd0, 1'b1, 16'hFF47, 1'b0};
        vecs[5] = '{16'h0000, 2'd0, 1'b0, 16'h0000, 1'b0};
        vecs[6] = '{16'h0100, 2'd0, 1'b1, 16'hF100, 1'b0};
        vecs[7] = '{16'h9876, 2'd0, 1'b1, 16'h9876, 1'b0};
        vecs[8] = '{16'h000F, 2'd0, 1'b1, 16'hFFFF, 1'b1};

        // Reset state, with load held high while in reset.
        value_in = 16'h1234;
        mode_in  = 2'd0;
        load     = 1'b1;
        #12;
        chk("rst_an", {12'd0, an}, 16'h000F);
        chk("rst_bcd", {12'd0, BCDout}, 16'h000F);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;

        // Idle: blank display, load during reset ignored.
        expect_frame(16'hFFFF, 1'b0);
        check_frame("idle");

        // Numeric load early in a frame.
        repeat (5) @(negedge clk);
        do_load(16'h1234, 2'd0, 1'b0);
        expect_frame(16'h1234, 1'b0);
        chk("pend_busy", {15'd0, busy}, 16'd1);
        to_boundary();
        chk("busy_at_boundary", {15'd0, busy}, 16'd1);
        check_frame("num1234");

        // Last load wins; then all-zero with blanking.
        do_load(16'h0047, 2'd0, 1'b1);
        repeat (3) @(negedge clk);
        do_load(16'h0900, 2'd0, 1'b1);
        expect_frame(16'hF900, 1'b0);
        chk("overwrite_busy", {15'd0, busy}, 16'd1);
        check_frame("last_wins");
        do_load(16'h0000, 2'd0, 1'b1);
        expect_frame(16'hFFF0, 1'b0);
        check_frame("lzb_zero");

        // Loads on the boundary cycle commit at once.
        to_boundary();
        do_load(16'h0000, 2'd2, 1'b0);
        expect_frame(16'hFBCE, 1'b0);
        chk("bnd_bus_busy", {15'd0, busy}, 16'd0);
        check_frame("bus");
        to_boundary();
        do_load(16'h0000, 2'd1, 1'b0);
        expect_frame(16'hFFA0, 1'b0);
        chk("bnd_go_busy", {15'd0, busy}, 16'd0);
        check_frame("go");

        // Code table, including err set and clear.
        for (int i = 0; i < 9; i++) begin
            repeat (1 + (i % 5)) @(negedge clk);
            do_load(vecs[i].value, vecs[i].mode, vecs[i].lzb);
            expect_frame(vecs[i].codes, vecs[i].err);
            check_frame($sformatf("vec%0d", i));
        end

        // Reset mid-slot with a pending load and err set.
        repeat (3) @(negedge clk);
        do_load(16'h1234, 2'd0, 1'b0);
        chk("pre_rst_busy", {15'd0, busy}, 16'd1);
        chk("pre_rst_err", {15'd0, err}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_an", {12'd0, an}, 16'h000F);
        chk("mid_rst_bcd", {12'd0, BCDout}, 16'h000F);
        chk("mid_rst_busy", {15'd0, busy}, 16'd0);
        chk("mid_rst_err", {15'd0, err}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_frame(16'hFFFF, 1'b0);
        check_frame("after_rst");
        expect_frame(16'hFFFF, 1'b0);
        check_frame("after_rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
